// File: rtl/bht_pkg.sv
// Shared types, defaults and the saturating counter step
// for the branch direction predictor.
package bht_pkg;

    typedef enum logic {INIT, RUN} state_t;

    localparam int DEF_INDEX_W = 5;
    localparam int DEF_CNT_W   = 2;
    localparam int DEF_GHR_W   = 0;
    localparam int CNT_MAX_W   = 16;

    function automatic logic [CNT_MAX_W-1:0] cnt_next(
        input logic [CNT_MAX_W-1:0] cnt,
        input logic                 taken,
        input logic [CNT_MAX_W-1:0] cmax
    );
        if (taken) begin
            return (cnt == cmax) ? cnt : cnt + 1'b1;
        end
        return (cnt == '0) ? cnt : cnt - 1'b1;
    endfunction

endpackage

// File: rtl/bht_ghr.sv
// Non-speculative global history register, shifted by
// resolved branch outcomes and cleared on flush.
module bht_ghr
    import bht_pkg::*;
#(
    parameter int GHR_W = 2
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             clr,
    input  logic             shift,
    input  logic             din,
    output logic [GHR_W-1:0] ghr
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ghr <= '0;
        end else if (clr) begin
            ghr <= '0;
        end else if (shift) begin
            ghr <= GHR_W'({ghr, din});
        end
    end

endmodule

// File: rtl/bht_predictor.sv
// Saturating-counter branch predictor with optional gshare
// hashing, write-first bypass and flush-driven re-init sweep.
module bht_predictor
    import bht_pkg::*;
#(
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int GHR_W    = DEF_GHR_W,
    parameter int INIT_VAL = 2 ** (CNT_W - 1) - 1
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               flush,
    output logic               ready,
    input  logic               lkp_valid,
    input  logic [INDEX_W-1:0] lkp_pc_idx,
    output logic               pred_valid,
    output logic               pred_taken,
    output logic [INDEX_W-1:0] pred_index,
    input  logic               upd_valid,
    input  logic [INDEX_W-1:0] upd_index,
    input  logic               upd_taken
);

    localparam int DEPTH = 1 << INDEX_W;
    localparam logic [CNT_MAX_W-1:0] CMAX =
        CNT_MAX_W'((1 << CNT_W) - 1);
    localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(INIT_VAL);
    localparam logic [INDEX_W-1:0] LAST = INDEX_W'(DEPTH - 1);

    state_t             state;
    logic [INDEX_W-1:0] sweep_idx;
    logic [CNT_W-1:0]   tbl [DEPTH];

    logic               lkp_acc;
    logic               upd_acc;
    logic [INDEX_W-1:0] ghr_ext;
    logic [INDEX_W-1:0] idx;
    logic [CNT_W-1:0]   upd_cnt;
    logic [CNT_W-1:0]   rd_cnt;

    assign ready   = (state == RUN);
    assign lkp_acc = lkp_valid & ready;
    assign upd_acc = upd_valid & ready;

    generate
        if (GHR_W > 0) begin : g_gshare
            logic [GHR_W-1:0] ghr;
            bht_ghr #(
                .GHR_W (GHR_W)
            ) u_ghr (
                .clk    (clk),
                .arst_n (arst_n),
                .clr    (flush),
                .shift  (upd_acc),
                .din    (upd_taken),
                .ghr    (ghr)
            );
            assign ghr_ext = INDEX_W'(ghr);
        end else begin : g_bimodal
            assign ghr_ext = '0;
        end
    endgenerate

    assign idx     = lkp_pc_idx ^ ghr_ext;
    assign upd_cnt = CNT_W'(cnt_next(CNT_MAX_W'(tbl[upd_index]),
                                     upd_taken, CMAX));

    // Same-entry update wins so the lookup sees the fresh count
    assign rd_cnt = (upd_acc && upd_index == idx) ? upd_cnt : tbl[idx];

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            tbl[sweep_idx] <= INIT_CNT;
        end else if (upd_acc) begin
            tbl[upd_index] <= upd_cnt;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= INIT;
            sweep_idx  <= '0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_index <= '0;
        end else begin
            if (flush) begin
                state     <= INIT;
                sweep_idx <= '0;
            end else begin
                case (state)
                    INIT: begin
                        sweep_idx <= sweep_idx + 1'b1;
                        if (sweep_idx == LAST) begin
                            state <= RUN;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
            pred_valid <= lkp_acc;
            pred_taken <= lkp_acc & rd_cnt[CNT_W-1];
            pred_index <= lkp_acc ? idx : '0;
        end
    end

endmodule

// File: tb/tb_bht_predictor.sv
// Scoreboard bench for bht_predictor: a bimodal instance against a
// table model, plus a gshare instance for history hashing.
module tb_bht_predictor;

    localparam int IW    = 5;
    localparam int DEPTH = 32;
    localparam int CMAXV = 3;
    localparam int INITV = 1;

    logic clk = 1'b0;
    logic arst_n = 1'b0;

    logic       flush = 0;
    logic       ready;
    logic       lkp_valid = 0;
    logic [4:0] lkp_pc_idx = 0;
    logic       pred_valid;
    logic       pred_taken;
    logic [4:0] pred_index;
    logic       upd_valid = 0;
    logic [4:0] upd_index = 0;
    logic       upd_taken = 0;

    logic       gs_ready;
    logic       gs_lv = 0;
    logic [4:0] gs_lpc = 0;
    logic       gs_pv;
    logic       gs_pt;
    logic [4:0] gs_pi;
    logic       gs_uv = 0;
    logic [4:0] gs_uidx = 0;
    logic       gs_ut = 0;

    bht_predictor u_dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .flush      (flush),
        .ready      (ready),
        .lkp_valid  (lkp_valid),
        .lkp_pc_idx (lkp_pc_idx),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_index (pred_index),
        .upd_valid  (upd_valid),
        .upd_index  (upd_index),
        .upd_taken  (upd_taken)
    );

    bht_predictor #(.GHR_W(2)) u_gs (
        .clk        (clk),
        .arst_n     (arst_n),
        .flush      (1'b0),
        .ready      (gs_ready),
        .lkp_valid  (gs_lv),
        .lkp_pc_idx (gs_lpc),
        .pred_valid (gs_pv),
        .pred_taken (gs_pt),
        .pred_index (gs_pi),
        .upd_valid  (gs_uv),
        .upd_index  (gs_uidx),
        .upd_taken  (gs_ut)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int taken;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;

    int   mcnt [DEPTH];
    bit   mready = 0;
    int   minit = DEPTH;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    // Reference: counters saturate in [0,3]; taken = upper half
    task automatic model_edge();
        int ui;
        int li;
        if (!mready) begin
            if (flush) minit = DEPTH;
            else minit--;
            if (minit == 0) begin
                mready = 1;
                foreach (mcnt[i]) mcnt[i] = INITV;
            end
            return;
        end
        ui = int'(upd_index);
        li = int'(lkp_pc_idx);
        if (upd_valid) begin
            if (upd_taken) mcnt[ui] = (mcnt[ui] + 1 > CMAXV) ? CMAXV
                                                             : mcnt[ui] + 1;
            else mcnt[ui] = (mcnt[ui] - 1 < 0) ? 0 : mcnt[ui] - 1;
        end
        if (lkp_valid) q.push_back('{li, (mcnt[li] >= 2) ? 1 : 0});
        if (flush) begin
            mready = 0;
            minit = DEPTH;
        end
    endtask

    task automatic cyc(input bit lv, input int lpc, input bit uv,
                       input int uidx, input bit ut, input bit fl);
        lkp_valid  = lv;
        lkp_pc_idx = 5'(lpc);
        upd_valid  = uv;
        upd_index  = 5'(uidx);
        upd_taken  = ut;
        flush      = fl;
        @(posedge clk);
        model_edge();
        #1;
        chk("ready", 32'(ready), 32'(mready));
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        chk("pred_valid", 32'(pred_valid), 32'(q.size() > 0));
        if (pred_valid && q.size() > 0) begin
            e = q.pop_front();
            chk("pred_taken", 32'(pred_taken), 32'(e.taken));
            chk("pred_index", 32'(pred_index), 32'(e.idx));
        end
    end

    initial begin
        gs_uv = 1;
        gs_ut = 1;
        #2;
        chk("rst_ready", 32'(ready), 0);
        chk("rst_pred_valid", 32'(pred_valid), 0);
        chk("rst_pred_taken", 32'(pred_taken), 0);
        chk("rst_pred_index", 32'(pred_index), 0);
        #10;
        arst_n = 1;

        for (int i = 0; i < 31; i++) begin
            if (i == 20) gs_uv = 0;
            idle();
        end
        chk("init_ready_low", 32'(ready), 0);
        idle();
        chk("init_ready_high", 32'(ready), 1);
        chk("gs_ready", 32'(gs_ready), 1);

        cyc(1, 7, 0, 0, 0, 0);
        chk("init_val_idx7", 32'(pred_taken), 0);

        repeat (3) cyc(0, 0, 1, 3, 1, 0);
        cyc(1, 3, 0, 0, 0, 0);
        chk("sat_hi_taken", 32'(pred_taken), 1);
        repeat (2) cyc(0, 0, 1, 3, 0, 0);
        cyc(1, 3, 0, 0, 0, 0);
        chk("down_to_01", 32'(pred_taken), 0);
        repeat (2) cyc(0, 0, 1, 3, 0, 0);
        repeat (2) cyc(0, 0, 1, 3, 1, 0);
        cyc(1, 3, 0, 0, 0, 0);
        chk("sat_lo_no_wrap", 32'(pred_taken), 1);

        cyc(1, 5, 1, 5, 1, 0);
        chk("bypass_idx5", 32'(pred_taken), 1);
        cyc(1, 6, 1, 5, 0, 0);
        chk("diff_idx6", 32'(pred_taken), 0);
        cyc(1, 5, 0, 0, 0, 0);
        chk("idx5_after", 32'(pred_taken), 0);

        repeat (3) cyc(0, 0, 1, 3, 1, 0);
        cyc(1, 3, 0, 0, 0, 1);
        chk("flush_pred_valid", 32'(pred_valid), 1);
        chk("flush_pred_taken", 32'(pred_taken), 1);
        chk("flush_ready_low", 32'(ready), 0);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1, $urandom_range(0, 31), 1, 3, 1, 0);
        end
        chk("flush_ready_back", 32'(ready), 1);
        cyc(1, 3, 0, 0, 0, 0);
        chk("flush_idx3_init", 32'(pred_taken), 0);

        gs_lv  = 1;
        gs_lpc = 4;
        idle();
        gs_lv = 0;
        chk("gs_ghr_zero_pv", 32'(gs_pv), 1);
        chk("gs_ghr_zero_idx", 32'(gs_pi), 4);
        gs_uv   = 1;
        gs_ut   = 1;
        gs_uidx = 2;
        repeat (2) idle();
        gs_uv = 0;
        gs_lv = 1;
        idle();
        gs_lv = 0;
        chk("gs_hash_idx", 32'(gs_pi), 7);

        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 31),
                $urandom_range(0, 1), $urandom_range(0, 31),
                $urandom_range(0, 1), $urandom_range(0, 199) == 0);
        end

        while (!mready) idle();
        repeat (2) cyc(0, 0, 1, 9, 1, 0);
        cyc(1, 9, 0, 0, 0, 0);
        chk("pre_arst_pv", 32'(pred_valid), 1);
        arst_n = 0;
        #1;
        chk("arst_ready", 32'(ready), 0);
        chk("arst_pred_valid", 32'(pred_valid), 0);
        chk("arst_pred_taken", 32'(pred_taken), 0);
        chk("arst_pred_index", 32'(pred_index), 0);
        q.delete();
        mready = 0;
        minit  = DEPTH;
        #1;
        arst_n = 1;
        for (int i = 0; i < 150; i++) begin
            cyc($urandom_range(0, 1), $urandom_range(0, 31),
                $urandom_range(0, 1), $urandom_range(0, 31),
                $urandom_range(0, 1), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
